fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RISC-V core. It is directly upstream of the branch target buffer: it drives the current fetch PC into the buffer and loads the buffer's combinational next-PC.
- It issues one instruction-memory request at a time over a valid/ready handshake, tolerates variable response latency, and fills the IF/ID pipeline register.
- On a mispredict flag from the buffer it flushes IF/ID and discards any stale in-flight response.

Parameters:
PC_W, 12, fetch address width (matches the buffer's 12-bit PC)
INST_W, 32, instruction width
RESET_PC, 0, PC value after reset
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
pc  out  PC_W  current fetch PC; drives the buffer's pc input
bp_next_pc  in  PC_W  buffer's nextPc (already the corrected target when mispredicting)
bp_mispredict  in  1  buffer's misPredict, combinational, valid each cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  PC_W  request address (= pc)
imem_rsp_valid  in  1  response valid, exactly one per accepted request, latency >= 1
imem_rsp_data  in  INST_W  fetched instruction
id_stall  in  1  hazard unit holds IF/ID
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  PC_W  PC of IF/ID instruction
if_id_inst  out  INST_W  IF/ID instruction

Behaviour:
- Reset (RST=1 at edge):
  - pc=RESET_PC, state=S_REQ.
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST.
  - Hold buffer is cleared.
  - Reset overrides every other input.
- imem_req_valid=1 only in S_REQ; imem_addr=pc always.
- At most one outstanding request.
- State S_REQ:
  - Accept (valid&ready) with no mispredict: go to S_WAIT.
  - Accept with mispredict: pc<=bp_next_pc, go to S_DISCARD.
  - Not accepted with mispredict: pc<=bp_next_pc, stay in S_REQ; the request address changes next cycle.
- State S_WAIT:
  - rsp_valid, no mispredict, !id_stall: deliver (load IF/ID with pc and rsp_data, valid=1), pc<=bp_next_pc, go to S_REQ.
  - rsp_valid, no mispredict, id_stall: capture rsp_data in the hold buffer, go to S_HOLD.
  - Mispredict with rsp_valid: drop the response, pc<=bp_next_pc, go to S_REQ.
  - Mispredict without rsp_valid: pc<=bp_next_pc, go to S_DISCARD.
- State S_HOLD:
  - !id_stall and no mispredict: deliver from the hold buffer, pc<=bp_next_pc, go to S_REQ.
  - Mispredict: drop the buffer, pc<=bp_next_pc, go to S_REQ.
- State S_DISCARD:
  - rsp_valid: drop the response, go to S_REQ.
  - A further mispredict: pc<=bp_next_pc, stay; if coincident with rsp_valid, still go to S_REQ.
- IF/ID update priority, highest first:
  1. Reset.
  2. Mispredict: valid=0, inst=NOP_INST, pc field unchanged.
  3. id_stall: hold all fields.
  4. Deliver: load.
  5. Otherwise: bubble, valid=0, inst=NOP_INST.
- pc advances only on deliver or mispredict, so bp_next_pc is sampled only while pc is the PC being retired into IF/ID.
- PC arithmetic belongs to the buffer; this block never adds 4. Wrap-around at 2^PC_W is inherited.
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency (request cycle + response cycle). Pipelining beyond this is out of scope.

Decomposition:
- Shared package `fetch_pkg`: state enum (S_REQ, S_WAIT, S_HOLD, S_DISCARD), NOP_INST, the RISC-V opcode constants for branch/jal/jalr already used by the buffer, and the PC_W default.
- One natural sub-module: `if_id_reg`, the IF/ID register with flush > stall > load > bubble priority.
- The FSM and hold buffer stay in `fetch_stage`.

Test Plan:
- Reset then free run: RST=1 for 2 cycles; memory always ready, 1-cycle latency; bp_next_pc=pc+4. Expect the first request at addr 0, if_id_pc sequence 0,4,8 with if_id_valid=1 every second cycle, and if_id_inst=NOP_INST while invalid.
- Stall with hold: id_stall=1 in the cycle the response for 0x010 (data 0x00500093) arrives. Expect IF/ID held, no new request, state S_HOLD. On release, next edge gives if_id_pc=0x010, if_id_inst=0x00500093.
- Mispredict in flight: request for 0x020 accepted, then bp_mispredict=1 with bp_next_pc=0x100 before the response. Expect that response (latency 3) dropped, IF/ID flushed to NOP/valid=0, next request addr 0x100.
- Mispredict with stall: id_stall=1 and bp_mispredict=1 together. Expect if_id_valid=0 (flush wins), pc=bp_next_pc.
- Backpressure: imem_req_ready=0 for 4 cycles. Expect imem_req_valid and imem_addr stable, no IF/ID load. A mispredict to 0x040 mid-wait changes imem_addr to 0x040 the next cycle.
- Reset mid-operation: RST=1 while in S_WAIT. Expect pc=0 and if_id_valid=0 next cycle. A late response arriving in the reset cycle is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W_DEFAULT   = 12;
    localparam int unsigned INST_W_DEFAULT = 32;

    // addi x0,x0,0 -- the bubble placed in IF/ID when it holds no instruction
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Control-flow opcodes, shared with the branch target buffer
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    function automatic logic is_ctrl_flow(input logic [31:0] inst);
        return (inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_JAL) ||
               (inst[6:0] == OPC_JALR);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
module if_id_reg #(
    parameter int unsigned       PC_W     = 12,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              stall,
    input  logic              load,
    input  logic [PC_W-1:0]   load_pc,
    input  logic [INST_W-1:0] load_inst,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst
);
    import fetch_pkg::*;

    // Register update; a flush leaves the pc field untouched
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (stall) begin
            valid <= valid;
            pc    <= pc;
            inst  <= inst;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, hold buffer for
// stalled responses, and mispredict recovery that discards stale data.
module fetch_stage #(
    parameter int unsigned       PC_W     = fetch_pkg::PC_W_DEFAULT,
    parameter int unsigned       INST_W   = fetch_pkg::INST_W_DEFAULT,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   bp_next_pc,
    input  logic              bp_mispredict,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              id_stall,
    output logic              if_id_valid,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [INST_W-1:0] if_id_inst
);
    import fetch_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [INST_W-1:0] hold_inst;
    logic              hold_load;
    logic              deliver;
    logic [INST_W-1:0] deliver_inst;
    logic              req_fire;

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // State, fetch PC and hold buffer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            hold_inst <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (hold_load) begin
                hold_inst <= imem_rsp_data;
            end
        end
    end

    // Next state, PC advance and IF/ID load selection
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_load    = 1'b0;
        deliver      = 1'b0;
        deliver_inst = (state == S_HOLD) ? hold_inst : imem_rsp_data;
        unique case (state)
            S_REQ: begin
                if (bp_mispredict) begin
                    pc_nxt    = bp_next_pc;
                    // an accepted request still owes a response that must be dropped
                    state_nxt = req_fire ? S_DISCARD : S_REQ;
                end else if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bp_mispredict) begin
                    pc_nxt    = bp_next_pc;
                    state_nxt = imem_rsp_valid ? S_REQ : S_DISCARD;
                end else if (imem_rsp_valid) begin
                    if (id_stall) begin
                        hold_load = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        deliver   = 1'b1;
                        pc_nxt    = bp_next_pc;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (bp_mispredict) begin
                    pc_nxt    = bp_next_pc;
                    state_nxt = S_REQ;
                end else if (!id_stall) begin
                    deliver   = 1'b1;
                    pc_nxt    = bp_next_pc;
                    state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                if (bp_mispredict) begin
                    pc_nxt = bp_next_pc;
                end
                if (imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    if_id_reg #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (bp_mispredict),
        .stall     (id_stall),
        .load      (deliver),
        .load_pc   (pc),
        .load_inst (deliver_inst),
        .valid     (if_id_valid),
        .pc        (if_id_pc),
        .inst      (if_id_inst)
    );

endmodule
